// File: rtl/dm_sba_controller.sv
// System Bus Access sequencer: runs one req/gnt/rvalid bus transaction per
// sbdata/sbaddress trigger and reports data, errors and the incremented address.
module dm_sba_controller #(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [BusWidth-1:0] sbaddress_i,
    input  logic [BusWidth-1:0] sbdata_i,
    input  logic [2:0]          sbaccess_i,
    input  logic                sbautoincrement_i,
    input  logic                sbreadonaddr_i,
    input  logic                sbreadondata_i,
    input  logic                sbaddress_write_valid_i,
    input  logic                sbdata_read_valid_i,
    input  logic                sbdata_write_valid_i,
    output logic                sbbusy_o,
    output logic [BusWidth-1:0] sbdata_o,
    output logic                sbdata_valid_o,
    output logic [2:0]          sberror_o,
    output logic                sberror_valid_o,
    output logic [BusWidth-1:0] sbaddress_o,
    output logic                sbaddress_valid_o,
    output logic                master_req_o,
    output logic [BusWidth-1:0] master_add_o,
    output logic                master_we_o,
    output logic [BusWidth-1:0] master_wdata_o,
    output logic [3:0]          master_be_o,
    input  logic                master_gnt_i,
    input  logic                master_r_valid_i,
    input  logic                master_r_err_i,
    input  logic [BusWidth-1:0] master_r_rdata_i
);

    localparam int unsigned     CntW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, RD_WAIT, WR_WAIT} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BusWidth-1:0] addr_q, addr_d;
    logic [2:0]          access_q, access_d;
    logic [BusWidth-1:0] wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic [BusWidth-1:0] sbdata_q, sbdata_d;
    logic                sbdata_valid_q, sbdata_valid_d;
    logic [2:0]          sberror_q, sberror_d;
    logic                sberror_valid_q, sberror_valid_d;
    logic [BusWidth-1:0] sbaddr_q, sbaddr_d;
    logic                sbaddr_valid_q, sbaddr_valid_d;

    logic                write_trig, read_trig, misaligned;
    logic [1:0]          offset;
    logic [3:0]          be_new;
    logic [BusWidth-1:0] wdata_new, rdata_shifted;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            addr_q          <= '0;
            access_q        <= '0;
            wdata_q         <= '0;
            be_q            <= '0;
            sbdata_q        <= '0;
            sbdata_valid_q  <= 1'b0;
            sberror_q       <= '0;
            sberror_valid_q <= 1'b0;
            sbaddr_q        <= '0;
            sbaddr_valid_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            addr_q          <= addr_d;
            access_q        <= access_d;
            wdata_q         <= wdata_d;
            be_q            <= be_d;
            sbdata_q        <= sbdata_d;
            sbdata_valid_q  <= sbdata_valid_d;
            sberror_q       <= sberror_d;
            sberror_valid_q <= sberror_valid_d;
            sbaddr_q        <= sbaddr_d;
            sbaddr_valid_q  <= sbaddr_valid_d;
        end
    end

    always_comb begin
        write_trig = sbdata_write_valid_i;
        read_trig  = (sbaddress_write_valid_i & sbreadonaddr_i) |
                     (sbdata_read_valid_i & sbreadondata_i);
        offset     = sbaddress_i[1:0];
        misaligned = ((sbaccess_i == 3'd1) && offset[0]) ||
                     ((sbaccess_i == 3'd2) && (offset != 2'b00));

        case (sbaccess_i)
            3'd0:    begin be_new = 4'b0001 << offset; wdata_new = {4{sbdata_i[7:0]}};  end
            3'd1:    begin be_new = 4'b0011 << offset; wdata_new = {2{sbdata_i[15:0]}}; end
            default: begin be_new = 4'hF;              wdata_new = sbdata_i;            end
        endcase

        rdata_shifted = master_r_rdata_i >> {addr_q[1:0], 3'b000};

        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        access_d        = access_q;
        wdata_d         = wdata_q;
        be_d            = be_q;
        sbdata_d        = sbdata_q;
        sbdata_valid_d  = 1'b0;
        sberror_d       = sberror_q;
        sberror_valid_d = 1'b0;
        sbaddr_d        = sbaddr_q;
        sbaddr_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (write_trig || read_trig) begin
                    if (sbaccess_i > 3'd2) begin
                        sberror_d       = 3'd4;
                        sberror_valid_d = 1'b1;
                    end else if (misaligned) begin
                        sberror_d       = 3'd3;
                        sberror_valid_d = 1'b1;
                    end else begin
                        addr_d   = sbaddress_i;
                        access_d = sbaccess_i;
                        be_d     = be_new;
                        wdata_d  = wdata_new;
                        state_d  = write_trig ? WR_REQ : RD_REQ;
                    end
                end
            end
            RD_REQ, WR_REQ: begin
                if (master_gnt_i) begin
                    cnt_d   = '0;
                    state_d = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
                end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
                    cnt_d           = '0;
                    sberror_d       = 3'd1;
                    sberror_valid_d = 1'b1;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (master_r_valid_i) begin
                    state_d = IDLE;
                    if (master_r_err_i) begin
                        sberror_d       = 3'd2;
                        sberror_valid_d = 1'b1;
                    end else begin
                        if (state_q == RD_WAIT) begin
                            sbdata_valid_d = 1'b1;
                            case (access_q)
                                3'd0:    sbdata_d = BusWidth'(rdata_shifted[7:0]);
                                3'd1:    sbdata_d = BusWidth'(rdata_shifted[15:0]);
                                default: sbdata_d = rdata_shifted;
                            endcase
                        end
                        if (sbautoincrement_i) begin
                            sbaddr_d       = sbaddress_i + (BusWidth'(1) << access_q);
                            sbaddr_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sbbusy_o          = (state_q != IDLE);
    assign master_req_o      = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign master_we_o       = (state_q == WR_REQ);
    assign master_add_o      = {addr_q[BusWidth-1:2], 2'b00};
    assign master_wdata_o    = wdata_q;
    assign master_be_o       = be_q;
    assign sbdata_o          = sbdata_q;
    assign sbdata_valid_o    = sbdata_valid_q;
    assign sberror_o         = sberror_q;
    assign sberror_valid_o   = sberror_valid_q;
    assign sbaddress_o       = sbaddr_q;
    assign sbaddress_valid_o = sbaddr_valid_q;

endmodule

// File: tb/tb_dm_sba_controller.sv
// Scoreboard bench for dm_sba_controller: a bus responder checks requests and a
// monitor checks data/error/address pulses against queues filled by the stimulus model.
module tb_dm_sba_controller;

    localparam int unsigned Timeout = 8;
    localparam logic [1:0] KIND_DATA = 2'd0;
    localparam logic [1:0] KIND_ERR  = 2'd1;
    localparam logic [1:0] KIND_ADDR = 2'd2;

    typedef struct {
        logic [31:0] add;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] value;
    } resp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] sbaddress_i = '0;
    logic [31:0] sbdata_i = '0;
    logic [2:0]  sbaccess_i = '0;
    logic        sbautoincrement_i = 1'b0;
    logic        sbreadonaddr_i = 1'b0;
    logic        sbreadondata_i = 1'b0;
    logic        sbaddress_write_valid_i = 1'b0;
    logic        sbdata_read_valid_i = 1'b0;
    logic        sbdata_write_valid_i = 1'b0;
    logic        sbbusy_o;
    logic [31:0] sbdata_o;
    logic        sbdata_valid_o;
    logic [2:0]  sberror_o;
    logic        sberror_valid_o;
    logic [31:0] sbaddress_o;
    logic        sbaddress_valid_o;
    logic        master_req_o;
    logic [31:0] master_add_o;
    logic        master_we_o;
    logic [31:0] master_wdata_o;
    logic [3:0]  master_be_o;
    logic        master_gnt_i = 1'b0;
    logic        master_r_valid_i = 1'b0;
    logic        master_r_err_i = 1'b0;
    logic [31:0] master_r_rdata_i = '0;

    int          assertCount = 0;
    int          failCount = 0;
    req_t        expReq[$];
    resp_t       expResp[$];
    logic        stall_gnt = 1'b0;
    int          gnt_delay = 0;
    int          resp_delay = 0;
    logic [31:0] resp_rdata = '0;
    logic        resp_err = 1'b0;

    dm_sba_controller #(.BusWidth(32), .TimeoutCycles(Timeout)) dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .sbaddress_i             (sbaddress_i),
        .sbdata_i                (sbdata_i),
        .sbaccess_i              (sbaccess_i),
        .sbautoincrement_i       (sbautoincrement_i),
        .sbreadonaddr_i          (sbreadonaddr_i),
        .sbreadondata_i          (sbreadondata_i),
        .sbaddress_write_valid_i (sbaddress_write_valid_i),
        .sbdata_read_valid_i     (sbdata_read_valid_i),
        .sbdata_write_valid_i    (sbdata_write_valid_i),
        .sbbusy_o                (sbbusy_o),
        .sbdata_o                (sbdata_o),
        .sbdata_valid_o          (sbdata_valid_o),
        .sberror_o               (sberror_o),
        .sberror_valid_o         (sberror_valid_o),
        .sbaddress_o             (sbaddress_o),
        .sbaddress_valid_o       (sbaddress_valid_o),
        .master_req_o            (master_req_o),
        .master_add_o            (master_add_o),
        .master_we_o             (master_we_o),
        .master_wdata_o          (master_wdata_o),
        .master_be_o             (master_be_o),
        .master_gnt_i            (master_gnt_i),
        .master_r_valid_i        (master_r_valid_i),
        .master_r_err_i          (master_r_err_i),
        .master_r_rdata_i        (master_r_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkResp(input logic [1:0] kind, input logic [31:0] value);
        resp_t e;
        checkOutput("resp_expected", 32'(expResp.size() != 0), 32'd1);
        if (expResp.size() != 0) begin
            e = expResp.pop_front();
            checkOutput("resp_kind", 32'(kind), 32'(e.kind));
            checkOutput(kind == KIND_DATA ? "sbdata" : kind == KIND_ERR ? "sberror" : "sbaddress",
                        value, e.value);
        end
    endtask

    // Pulses are registered, so they are checked one negedge after the causing edge
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (sbdata_valid_o)    checkResp(KIND_DATA, sbdata_o);
                if (sberror_valid_o)   checkResp(KIND_ERR, 32'(sberror_o));
                if (sbaddress_valid_o) checkResp(KIND_ADDR, sbaddress_o);
            end
        end
    end

    // Bus slave model: grants after gnt_delay, answers after resp_delay
    initial begin
        req_t r;
        forever begin
            @(negedge clk_i);
            if (rst_ni && master_req_o && !stall_gnt) begin
                repeat (gnt_delay) @(negedge clk_i);
                checkOutput("req_held", 32'(master_req_o), 32'd1);
                checkOutput("req_expected", 32'(expReq.size() != 0), 32'd1);
                if (expReq.size() != 0) begin
                    r = expReq.pop_front();
                    checkOutput("master_add", master_add_o, r.add);
                    checkOutput("master_we", 32'(master_we_o), 32'(r.we));
                    checkOutput("master_be", 32'(master_be_o), 32'(r.be));
                    if (r.we) checkOutput("master_wdata", master_wdata_o, r.wdata);
                end
                master_gnt_i = 1'b1;
                @(negedge clk_i);
                master_gnt_i = 1'b0;
                checkOutput("req_drop", 32'(master_req_o), 32'd0);
                repeat (resp_delay) @(negedge clk_i);
                master_r_valid_i = 1'b1;
                master_r_err_i   = resp_err;
                master_r_rdata_i = resp_rdata;
                @(negedge clk_i);
                master_r_valid_i = 1'b0;
                master_r_err_i   = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] access,
                                 input logic autoinc, input logic rd_on_addr, input logic rd_on_data,
                                 input logic addr_wr, input logic data_rd, input logic data_wr,
                                 input logic [31:0] rdata, input logic rerr, input logic expect_timeout);
        logic  is_wr, is_rd;
        logic [1:0] off;
        req_t  r;
        logic [31:0] sh;
        resp_runs: begin end
        resp_rdata = rdata;
        resp_err   = rerr;
        @(negedge clk_i);
        sbaddress_i             = addr;
        sbdata_i                = data;
        sbaccess_i              = access;
        sbautoincrement_i       = autoinc;
        sbreadonaddr_i          = rd_on_addr;
        sbreadondata_i          = rd_on_data;
        sbaddress_write_valid_i = addr_wr;
        sbdata_read_valid_i     = data_rd;
        sbdata_write_valid_i    = data_wr;
        is_wr = data_wr;
        is_rd = (addr_wr & rd_on_addr) | (data_rd & rd_on_data);
        off   = addr[1:0];
        if (is_wr || is_rd) begin
            if (access > 3'd2) begin
                expResp.push_back('{KIND_ERR, 32'd4});
            end else if ((access == 3'd1 && off[0]) || (access == 3'd2 && off != 2'b00)) begin
                expResp.push_back('{KIND_ERR, 32'd3});
            end else begin
                r.add = {addr[31:2], 2'b00};
                r.we  = is_wr;
                case (access)
                    3'd0:    begin r.be = 4'b0001 << off; r.wdata = {4{data[7:0]}};  end
                    3'd1:    begin r.be = 4'b0011 << off; r.wdata = {2{data[15:0]}}; end
                    default: begin r.be = 4'hF;           r.wdata = data;            end
                endcase
                sh = rdata >> (8 * off);
                if (expect_timeout) begin
                    expResp.push_back('{KIND_ERR, 32'd1});
                end else begin
                    expReq.push_back(r);
                    if (rerr) begin
                        expResp.push_back('{KIND_ERR, 32'd2});
                    end else begin
                        if (!is_wr) begin
                            case (access)
                                3'd0:    expResp.push_back('{KIND_DATA, sh & 32'h0000_00FF});
                                3'd1:    expResp.push_back('{KIND_DATA, sh & 32'h0000_FFFF});
                                default: expResp.push_back('{KIND_DATA, sh});
                            endcase
                        end
                        if (autoinc) expResp.push_back('{KIND_ADDR, addr + (32'd1 << access)});
                    end
                end
            end
        end
        @(negedge clk_i);
        sbaddress_write_valid_i = 1'b0;
        sbdata_read_valid_i     = 1'b0;
        sbdata_write_valid_i    = 1'b0;
    endtask

    task automatic pulseTrigger();
        @(negedge clk_i);
        sbdata_write_valid_i    = 1'b1;
        sbaddress_write_valid_i = 1'b1;
        @(negedge clk_i);
        sbdata_write_valid_i    = 1'b0;
        sbaddress_write_valid_i = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (!sbbusy_o) break;
        end
        checkOutput("busy_clear", 32'(sbbusy_o), 32'd0);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        int reqCycles;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_busy", 32'(sbbusy_o), 32'd0);
        checkOutput("rst_req", 32'(master_req_o), 32'd0);
        checkOutput("rst_add", master_add_o, 32'd0);
        checkOutput("rst_be", 32'(master_be_o), 32'd0);
        checkOutput("rst_err_valid", 32'(sberror_valid_o), 32'd0);
        checkOutput("rst_data_valid", 32'(sbdata_valid_o), 32'd0);
        checkOutput("rst_addr_valid", 32'(sbaddress_valid_o), 32'd0);
        checkOutput("rst_sbdata", sbdata_o, 32'd0);
        rst_ni = 1'b1;

        gnt_delay = 2; resp_delay = 1;
        applyStimulus(32'h1000, 32'hDEADBEEF, 3'd2, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        waitIdle();
        gnt_delay = 0; resp_delay = 0;
        applyStimulus(32'h1003, 32'h0, 3'd0, 0, 1, 0, 1, 0, 0, 32'h12345678, 0, 0);
        waitIdle();
        applyStimulus(32'hFFFFFFFE, 32'h0, 3'd1, 1, 1, 0, 1, 0, 0, 32'hA5A5_1234, 0, 0);
        waitIdle();
        applyStimulus(32'h1001, 32'h0000_00AB, 3'd0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        waitIdle();
        resp_delay = 2;
        applyStimulus(32'h2002, 32'h1234_BEEF, 3'd1, 1, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        waitIdle();
        applyStimulus(32'hFFFFFFFC, 32'h0BAD_F00D, 3'd2, 1, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        waitIdle();
        resp_delay = 0;
        applyStimulus(32'h3000, 32'h0, 3'd2, 0, 0, 1, 0, 1, 0, 32'hCAFEF00D, 0, 0);
        waitIdle();
        applyStimulus(32'h3000, 32'h0, 3'd2, 0, 0, 0, 0, 1, 0, 32'hCAFEF00D, 0, 0);
        waitIdle();

        applyStimulus(32'h1002, 32'h1, 3'd2, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        waitIdle();
        applyStimulus(32'h1001, 32'h1, 3'd1, 0, 1, 0, 1, 0, 0, 32'h0, 0, 0);
        waitIdle();
        applyStimulus(32'h1000, 32'h1, 3'd3, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        waitIdle();

        stall_gnt = 1'b1;
        applyStimulus(32'h4000, 32'h0, 3'd2, 0, 1, 0, 1, 0, 0, 32'h0, 0, 1);
        checkOutput("busy_in_req", 32'(sbbusy_o), 32'd1);
        reqCycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (master_req_o) reqCycles++;
            else if (reqCycles > 0) break;
            @(negedge clk_i);
        end
        checkOutput("timeout_req_cycles", 32'(reqCycles), 32'(Timeout));
        stall_gnt = 1'b0;
        waitIdle();
        applyStimulus(32'h4004, 32'h0, 3'd2, 1, 1, 0, 1, 0, 0, 32'h5555_5555, 1, 0);
        waitIdle();

        applyStimulus(32'h5000, 32'h7777_8888, 3'd2, 0, 1, 0, 1, 0, 1, 32'h0, 0, 0);
        waitIdle();
        stall_gnt = 1'b1;
        applyStimulus(32'h5004, 32'h1111_2222, 3'd2, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        pulseTrigger();
        stall_gnt = 1'b0;
        waitIdle();
        repeat (3) @(negedge clk_i);
        checkOutput("no_retrigger_req", 32'(master_req_o), 32'd0);

        stall_gnt = 1'b1;
        applyStimulus(32'h6000, 32'h3333_4444, 3'd2, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checkOutput("async_rst_busy", 32'(sbbusy_o), 32'd0);
        checkOutput("async_rst_req", 32'(master_req_o), 32'd0);
        expReq.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        stall_gnt = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("post_rst_req", 32'(master_req_o), 32'd0);

        checkOutput("req_queue_empty", 32'(expReq.size()), 32'd0);
        checkOutput("resp_queue_empty", 32'(expResp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
